// File: rtl/inst_mem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Optional build macro used by the arbiter: INST_MEM_CHECKSUM_EN.
package inst_mem_pkg;

  localparam int ADDR_W_DEF = 17;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 131072;

  // Owner of the BRAM port and core start-up phase.
  typedef enum logic [2:0] {
    LOAD,
    DRAIN,
    RUN,
    DBG_ISSUE,
    DBG_WAIT,
    HALT
  } state_e;

endpackage

// File: rtl/inst_mem_arbiter_load_writer.sv
// Loader write path: registers each accepted word into a BRAM write,
// range-checks the address, counts written words and, when
// INST_MEM_CHECKSUM_EN is defined, keeps a wrapping sum of them.
module load_writer
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hs,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count
`ifdef INST_MEM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  logic              in_range;
  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0] wr_data_d, wr_data_q;
  logic              err_d, err_q;
  logic [ADDR_W:0]   count_d, count_q;
`ifdef INST_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] sum_d, sum_q;
`endif

  assign in_range = ({1'b0, addr} < DEPTH_C);

  // Next-state for the write register, error flag, counter and checksum.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_en_d   = hs && in_range;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q | (hs && !in_range);
    count_d   = count_q;
    if (hs) begin
      wr_addr_d = addr;
      wr_data_d = data;
    end
    if (clear) begin
      count_d = '0;
    end else if (wr_en_d && (count_q != DEPTH_C)) begin
      count_d = count_q + ONE_C;
    end
`ifdef INST_MEM_CHECKSUM_EN
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (wr_en_d) begin
      sum_d = sum_q + data;
    end
`endif
  end

  // Registers; an asynchronous reset drops any in-flight write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      count_q   <= '0;
`ifdef INST_MEM_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      count_q   <= count_d;
`ifdef INST_MEM_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign load_err   = err_q;
  assign load_count = count_q;
`ifdef INST_MEM_CHECKSUM_EN
  assign load_sum   = sum_q;
`endif

endmodule

// File: rtl/inst_mem_arbiter.sv
// Instruction BRAM port arbiter: loader during start-up, then fetch,
// with debug reads while the core is stalled or halted.
// Optional build macro INST_MEM_CHECKSUM_EN adds the load_sum output.
module inst_mem_arbiter
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_done,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              core_run,
  input  logic              core_stall,
  input  logic              halt_req,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_data,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count,
`ifdef INST_MEM_CHECKSUM_EN
  output logic [DATA_W-1:0] load_sum,
`endif
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  state_e            state_d, state_q;
  logic              ret_halt_d, ret_halt_q;
  logic              ld_ready_d, ld_ready_q;
  logic              core_run_d, core_run_q;
  logic              dbg_ack_d, dbg_ack_q;
  logic [DATA_W-1:0] dbg_data_d, dbg_data_q;
  logic              hs, clear;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // ld_ready is only ever high in LOAD, so it alone qualifies the handshake.
  assign hs    = ld_valid && ld_ready_q;
  assign clear = (state_q == HALT) && ld_start;

  load_writer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_load_writer (
    .clk       (clk),
    .rstn      (rstn),
    .hs        (hs),
    .clear     (clear),
    .addr      (ld_addr),
    .data      (ld_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .load_err  (load_err),
`ifdef INST_MEM_CHECKSUM_EN
    .load_sum  (load_sum),
`endif
    .load_count(load_count)
  );

  // Arbitration FSM: next state plus next values of the registered outputs.
  // A debug read returns to whichever of RUN/HALT granted it, so a read
  // from a halted core does not restart it.
  always_comb begin
    state_d    = state_q;
    ret_halt_d = ret_halt_q;
    unique case (state_q)
      LOAD:      if (ld_done) state_d = DRAIN;
      DRAIN:     state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end else if (dbg_req && core_stall) begin
          state_d    = DBG_ISSUE;
          ret_halt_d = 1'b0;
        end
      end
      DBG_ISSUE: state_d = DBG_WAIT;
      DBG_WAIT:  state_d = ret_halt_q ? HALT : RUN;
      HALT: begin
        if (ld_start) begin
          state_d = LOAD;
        end else if (dbg_req) begin
          state_d    = DBG_ISSUE;
          ret_halt_d = 1'b1;
        end
      end
      default:   state_d = LOAD;
    endcase
    ld_ready_d = (state_d == LOAD);
    core_run_d = (state_d == RUN) ||
                 (((state_d == DBG_ISSUE) || (state_d == DBG_WAIT)) && !ret_halt_d);
    dbg_ack_d  = (state_q == DBG_WAIT);
    dbg_data_d = (state_q == DBG_WAIT) ? bram_dout : dbg_data_q;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= LOAD;
      ret_halt_q <= 1'b0;
      ld_ready_q <= 1'b0;
      core_run_q <= 1'b0;
      dbg_ack_q  <= 1'b0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ret_halt_q <= ret_halt_d;
      ld_ready_q <= ld_ready_d;
      core_run_q <= core_run_d;
      dbg_ack_q  <= dbg_ack_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  // BRAM address mux: fetch in RUN, debug while reading or halted, loader otherwise.
  always_comb begin
    bram_addr = wr_addr;
    unique case (state_q)
      RUN:                       bram_addr = fetch_addr;
      DBG_ISSUE, DBG_WAIT, HALT: bram_addr = dbg_addr;
      default:                   bram_addr = wr_addr;
    endcase
  end

  assign bram_we    = wr_en;
  assign bram_din   = wr_data;
  assign fetch_data = bram_dout;
  assign ld_ready   = ld_ready_q;
  assign core_run   = core_run_q;
  assign dbg_ack    = dbg_ack_q;
  assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Bench for inst_mem_arbiter: behavioural BRAM, a phase-level reference
// model checked every cycle, and directed checks with literal expectations.
// Build with INST_MEM_CHECKSUM_EN defined to cover load_sum as well.
module tb_inst_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              ld_valid, ld_ready, ld_done, ld_start;
  logic [ADDR_W-1:0] ld_addr, fetch_addr, dbg_addr, bram_addr;
  logic [DATA_W-1:0] ld_data, fetch_data, dbg_data, bram_din, bram_dout;
  logic              core_run, core_stall, halt_req, dbg_req, dbg_ack, bram_we, load_err;
  logic [ADDR_W:0]   load_count;
`ifdef INST_MEM_CHECKSUM_EN
  logic [DATA_W-1:0] load_sum;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  inst_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done), .ld_start(ld_start),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .core_run(core_run), .core_stall(core_stall), .halt_req(halt_req),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .load_err(load_err), .load_count(load_count),
`ifdef INST_MEM_CHECKSUM_EN
    .load_sum(load_sum),
`endif
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout)
  );

  // Behavioural single-port BRAM, read-first, one cycle read latency.
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr[7:0]] <= bram_din;
    bram_dout <= mem[bram_addr[7:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase codes: who owns the port and why.
  localparam int P_LOAD = 0, P_DRAIN = 1, P_RUN = 2, P_DBG1 = 3, P_DBG2 = 4, P_HALT = 5;
  int                m_phase;
  bit                m_from_halt;
  logic [DATA_W-1:0] m_mem   [0:255];
  bit                m_known [0:255];
  bit                m_hs;
  bit                e_ld_ready, e_core_run, e_we, e_ack, e_err, fetch_chk;
  logic [ADDR_W-1:0] e_waddr;
  logic [DATA_W-1:0] e_wdata, e_dbg_data, e_sum, fetch_exp;
  int                e_count;

  initial for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase = P_LOAD; m_from_halt = 1'b0;
      e_ld_ready = 0; e_core_run = 0; e_we = 0; e_ack = 0; e_err = 0; fetch_chk = 0;
      e_count = 0; e_sum = '0; e_dbg_data = '0;
    end else begin
      m_hs      = (m_phase == P_LOAD) && e_ld_ready && ld_valid;
      e_we      = 1'b0;
      e_ack     = 1'b0;
      fetch_chk = (m_phase == P_RUN) && m_known[fetch_addr[7:0]];
      fetch_exp = m_mem[fetch_addr[7:0]];
      if (m_hs) begin
        if (int'(ld_addr) < DEPTH) begin
          e_we = 1'b1; e_waddr = ld_addr; e_wdata = ld_data;
          m_mem[ld_addr[7:0]] = ld_data; m_known[ld_addr[7:0]] = 1'b1;
          if (e_count < DEPTH) e_count++;
          e_sum = e_sum + ld_data;
        end else begin
          e_err = 1'b1;
        end
      end
      case (m_phase)
        P_LOAD:  if (ld_done) m_phase = P_DRAIN;
        P_DRAIN: m_phase = P_RUN;
        P_RUN:   if (halt_req) m_phase = P_HALT;
                 else if (dbg_req && core_stall) begin m_phase = P_DBG1; m_from_halt = 0; end
        P_DBG1:  m_phase = P_DBG2;
        P_DBG2:  begin
                   e_ack = 1'b1; e_dbg_data = m_mem[dbg_addr[7:0]];
                   m_phase = m_from_halt ? P_HALT : P_RUN;
                 end
        default: if (ld_start) begin m_phase = P_LOAD; e_count = 0; e_sum = '0; end
                 else if (dbg_req) begin m_phase = P_DBG1; m_from_halt = 1; end
      endcase
      e_ld_ready = (m_phase == P_LOAD);
      e_core_run = (m_phase == P_RUN) ||
                   ((m_phase == P_DBG1 || m_phase == P_DBG2) && !m_from_halt);
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (rstn && chk_en) begin
      check("ld_ready", ld_ready, e_ld_ready);
      check("core_run", core_run, e_core_run);
      check("bram_we", bram_we, e_we);
      check("load_err", load_err, e_err);
      check("load_count", load_count, e_count);
      check("dbg_ack", dbg_ack, e_ack);
      if (e_we) begin
        check("bram_addr_wr", bram_addr, e_waddr);
        check("bram_din", bram_din, e_wdata);
      end
      if (m_phase == P_RUN) check("bram_addr_fetch", bram_addr, fetch_addr);
      if (m_phase == P_DBG1 || m_phase == P_HALT) check("bram_addr_dbg", bram_addr, dbg_addr);
      if (fetch_chk) check("fetch_data", fetch_data, fetch_exp);
      if (e_ack) check("dbg_data", dbg_data, e_dbg_data);
`ifdef INST_MEM_CHECKSUM_EN
      check("load_sum", load_sum, e_sum);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_core_run"}, core_run, 0);
    check({tag, "_bram_we"}, bram_we, 0);
    check({tag, "_bram_addr"}, bram_addr, 0);
    check({tag, "_bram_din"}, bram_din, 0);
    check({tag, "_dbg_ack"}, dbg_ack, 0);
    check({tag, "_dbg_data"}, dbg_data, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_load_count"}, load_count, 0);
`ifdef INST_MEM_CHECKSUM_EN
    check({tag, "_load_sum"}, load_sum, 0);
`endif
  endtask

  // Edges counted from the one that samples the request; -1 if none within bound.
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      if (dbg_ack) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic load_word(input int addr, input logic [31:0] data, input bit last);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = ADDR_W'(addr); ld_data = data; ld_done = last;
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    if (which == 0) halt_req = 1'b1; else ld_start = 1'b1;
    @(negedge clk);
    halt_req = 1'b0; ld_start = 1'b0;
  endtask

  initial begin
    int lat, acks;
    rstn = 1'b0; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_done = 0; ld_start = 0;
    fetch_addr = '0; core_stall = 0; halt_req = 0; dbg_req = 0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_vals("reset");
    rstn = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #2 check("ld_ready_rise", ld_ready, 1);

    // Out-of-range loader word: no write, sticky error, count unchanged.
    load_word(DEPTH, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #2;
    check("oor_err", load_err, 1);
    check("oor_count", load_count, 0);
    @(negedge clk); ld_valid = 1'b0;
    check("oor_no_we", bram_we, 0);

    // Four words, ld_done together with the last one.
    for (int i = 0; i < 4; i++) load_word(i, 32'(i + 1), i == 3);
    @(negedge clk); ld_valid = 1'b0; ld_done = 1'b0;
    check("drain_count", load_count, 4);
    check("drain_last_we", bram_we, 1);
    check("drain_ready", ld_ready, 0);
    check("drain_run", core_run, 0);
    @(posedge clk); #2 check("run_start", core_run, 1);

    // Fetch path: address combinational, data one cycle later.
    @(negedge clk); fetch_addr = 2;
    #1 check("fetch_addr_comb", bram_addr, 2);
    @(posedge clk); #2 check("fetch_data_2", fetch_data, 32'h3);

    // Debug read while stalled.
    @(negedge clk); core_stall = 1; dbg_req = 1; dbg_addr = 1;
    wait_ack(lat);
    check("dbg_latency", lat, 2);
    check("dbg_data_1", dbg_data, 32'h2);
    @(negedge clk); dbg_req = 0; core_stall = 0;

    // Same request without a stall is never granted.
    @(negedge clk); dbg_req = 1; dbg_addr = 1;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      if (dbg_ack) acks++;
    end
    check("dbg_nostall_acks", acks, 0);

    // halt_req and dbg_req together: halt wins.
    @(negedge clk); halt_req = 1;
    @(posedge clk); #2 check("halt_run", core_run, 0);
    @(negedge clk); halt_req = 0; dbg_req = 0;

    // Debug read in HALT without a stall.
    @(negedge clk); dbg_req = 1; dbg_addr = 3;
    wait_ack(lat);
    check("halt_dbg_latency", lat, 2);
    check("halt_dbg_data", dbg_data, 32'h4);
    check("halt_dbg_run", core_run, 0);
    @(negedge clk); dbg_req = 0;

    // Reload: count cleared, error kept; nine words saturate the count.
    pulse(1);
    check("reload_count", load_count, 0);
    check("reload_err", load_err, 1);
    check("reload_ready", ld_ready, 1);
    for (int i = 0; i < 9; i++) load_word(i % DEPTH, 32'(i + 1), i == 8);
    @(negedge clk); ld_valid = 1'b0; ld_done = 1'b0;
    check("sat_count", load_count, DEPTH);
    repeat (3) @(negedge clk);
    pulse(0);
    pulse(1);

    // Reset mid-load after two handshakes.
    load_word(0, 32'h11, 1'b0);
    load_word(1, 32'h22, 1'b0);
    @(negedge clk); ld_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check_reset_vals("midload");
    @(negedge clk); rstn = 1'b1;

    // Fresh load of 1..4.
    for (int i = 0; i < 4; i++) load_word(i, 32'(i + 1), i == 3);
    @(negedge clk); ld_valid = 1'b0; ld_done = 1'b0;
    check("fresh_count", load_count, 4);
    check("fresh_err", load_err, 0);
`ifdef INST_MEM_CHECKSUM_EN
    check("fresh_sum", load_sum, 32'h0000000A);
`endif
    @(negedge clk); fetch_addr = 3;
    @(posedge clk); #2 check("fetch_data_3", fetch_data, 32'h4);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
